// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus, with idle turnaround between owners.
// Optional hold-timeout forced release is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_owner_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     bus_busy,
  output logic                     timeout_pulse
);

  localparam int IdW = $clog2(N_REQ);

  // ARB sits between the IDLE decision and the grant edge, giving the two-cycle request latency.
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_TURN} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IdW-1:0]   owner_q, owner_d;
  logic [IdW-1:0]   start_q, start_d;
  logic [IdW-1:0]   cand_q, cand_d;
  logic [1:0]       turn_q, turn_d;
  logic             busy_q, busy_d;
  logic             release_req;
  logic             found;
  logic [IdW-1:0]   win;
  logic [IdW:0]     scan_sum;
  logic [IdW-1:0]   scan_idx;
`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0]       hold_q, hold_d;
  logic             tpulse_q, tpulse_d;
  logic             forced;
`endif

  // Scan from start_q upward with wrap; the first asserted request wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, start_q} + (IdW+1)'(i);
      if (scan_sum >= (IdW+1)'(N_REQ)) scan_sum = scan_sum - (IdW+1)'(N_REQ);
      scan_idx = scan_sum[IdW-1:0];
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    start_d     = start_q;
    cand_d      = cand_q;
    turn_d      = turn_q;
    release_req = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d      = hold_q;
    tpulse_d    = 1'b0;
    forced      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          cand_d  = win;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        grant_d          = '0;
        grant_d[cand_q]  = 1'b1;
        owner_d          = cand_q;
        start_d          = (cand_q == IdW'(N_REQ-1)) ? '0 : cand_q + 1'b1;
        state_d          = S_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d           = 8'd1;
`endif
      end
      S_GRANT: begin
        release_req = !req[owner_q];
`ifdef BUS_ARB_TIMEOUT_EN
        // An owner dropping req on the saturating cycle is a normal release, not a timeout.
        forced   = req[owner_q] && (hold_q == 8'(MAX_HOLD)) && |(req & ~grant_q);
        tpulse_d = forced;
        if (!release_req && !forced && hold_q != 8'(MAX_HOLD)) hold_d = hold_q + 8'd1;
        if (forced) release_req = 1'b1;
`endif
        if (release_req) begin
          grant_d = '0;
          turn_d  = '0;
          state_d = S_TURN;
        end
      end
      default: begin
        if (turn_q == 2'(TURN_CYCLES-1)) state_d = S_IDLE;
        else                             turn_d  = turn_q + 2'd1;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      start_q  <= '0;
      cand_q   <= '0;
      turn_q   <= '0;
      busy_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q   <= '0;
      tpulse_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      start_q  <= start_d;
      cand_q   <= cand_d;
      turn_q   <= turn_d;
      busy_q   <= busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q   <= hold_d;
      tpulse_q <= tpulse_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign bus_busy = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout_pulse = tpulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Scoreboard bench for bus_owner_arbiter: expected grants are queued by the stimulus and
// popped by an independent monitor each time a new grant appears on the bus.
module tb_bus_owner_arbiter;
  localparam int N    = 4;
  localparam int TURN = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] owner_id;
  logic       bus_busy;
  logic       timeout_pulse;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bus_owner_arbiter #(.N_REQ(N), .TURN_CYCLES(TURN), .MAX_HOLD(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .owner_id     (owner_id),
    .bus_busy     (bus_busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    @(posedge clk);
    #1;
    req = r;
  endtask

  task automatic pushExpect(input logic [3:0] gm, input logic [1:0] idm);
    exp_t e;
    e.g  = gm;
    e.id = idm;
    sb.push_back(e);
  endtask

  task automatic waitGrant(input logic [3:0] gm, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (grant !== gm && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, grant, gm);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: bus invariants every cycle, scoreboard pop and turnaround gap on each new grant.
  initial begin
    logic [3:0] prev;
    int         gap;
    bit         seen;
    exp_t       e;
    prev = '0;
    gap  = 0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '0;
        gap  = 0;
        seen = 1'b0;
      end else begin
        checkOutput("busy_eq_or_grant", bus_busy, |grant);
        checkOutput("grant_onehot0", $onehot0(grant), 1);
        if (grant != 4'b0000 && prev == 4'b0000) begin
          if (seen) checkOutput("turnaround_gap_ok", gap >= TURN + 1, 1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_grant: got %0h expected none", grant);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_grant", grant, e.g);
            checkOutput("sb_owner", owner_id, e.id);
          end
          seen = 1'b1;
        end
        if (grant == 4'b0000) gap++;
        else                  gap = 0;
        prev = grant;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         bad;
    int         tpcnt;
    int         cnt;
    logic [3:0] m;

    rst = 1'b1;
    req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_owner", owner_id, 0);
    checkOutput("reset_busy", bus_busy, 0);
    checkOutput("reset_tpulse", timeout_pulse, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request: exact two-edge grant latency and one-edge release.
    pushExpect(4'b0001, 2'd0);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    checkOutput("latency_after_edge_k", grant, 0);
    @(negedge clk);
    checkOutput("latency_after_edge_k1", grant, 4'b0001);
    checkOutput("single_owner", owner_id, 0);
    checkOutput("single_busy", bus_busy, 1);
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("still_granted_before_m", grant, 4'b0001);
    @(negedge clk);
    checkOutput("release_after_edge_m", grant, 0);
    checkOutput("release_busy", bus_busy, 0);
    repeat (4) @(posedge clk);

    // Round-robin rotation with all four requesting.
    doReset();
    pushExpect(4'b0001, 2'd0);
    pushExpect(4'b0010, 2'd1);
    pushExpect(4'b0100, 2'd2);
    pushExpect(4'b1000, 2'd3);
    pushExpect(4'b0001, 2'd0);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      m = 4'(1 << i);
      waitGrant(m, 20, "rr_grant");
      repeat (2) @(posedge clk);
      applyStimulus(req & ~m);
      waitGrant(4'b0000, 5, "rr_release");
      req = req | m;
    end

    // Wrap with sparse requests: owner 3 releases under req=0101.
    waitGrant(4'b0001, 20, "rr_wrap_owner0");
    repeat (2) @(posedge clk);
    pushExpect(4'b1000, 2'd3);
    applyStimulus(4'b1000);
    waitGrant(4'b1000, 20, "wrap_owner3");
    applyStimulus(4'b1101);
    pushExpect(4'b0001, 2'd0);
    pushExpect(4'b0100, 2'd2);
    applyStimulus(4'b0101);
    waitGrant(4'b0001, 20, "wrap_to_owner0");
    repeat (2) @(posedge clk);
    applyStimulus(4'b0100);
    waitGrant(4'b0100, 20, "wrap_then_owner2");

    // Mid-grant reset: after it, {2,3} pending must go to 2, not 3.
    applyStimulus(4'b1100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_grant", grant, 0);
    checkOutput("midrst_owner", owner_id, 0);
    checkOutput("midrst_busy", bus_busy, 0);
    checkOutput("midrst_tpulse", timeout_pulse, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushExpect(4'b0100, 2'd2);
    waitGrant(4'b0100, 20, "post_reset_scan_from_0");
    applyStimulus(4'b0000);
    waitGrant(4'b0000, 5, "post_reset_release");
    repeat (3) @(posedge clk);

    // Lone hog keeps the bus indefinitely.
    pushExpect(4'b0001, 2'd0);
    applyStimulus(4'b0001);
    waitGrant(4'b0001, 10, "hog_grant");
    bad   = 0;
    tpcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (grant !== 4'b0001) bad++;
      if (timeout_pulse !== 1'b0) tpcnt++;
    end
    checkOutput("hog_bad_cycles", bad, 0);
    checkOutput("hog_timeout_pulses", tpcnt, 0);
    applyStimulus(4'b0000);
    waitGrant(4'b0000, 5, "hog_release");

`ifdef BUS_ARB_TIMEOUT_EN
    // Forced release after 16 cycles with requester 1 waiting.
    doReset();
    pushExpect(4'b0001, 2'd0);
    pushExpect(4'b0010, 2'd1);
    req = 4'b0011;
    waitGrant(4'b0001, 10, "forced_first_grant");
    cnt = 0;
    while (grant == 4'b0001 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("forced_hold_cycles", cnt, 16);
    checkOutput("timeout_pulse_first_turn", timeout_pulse, 1);
    @(negedge clk);
    checkOutput("timeout_pulse_one_cycle", timeout_pulse, 0);
    waitGrant(4'b0010, 10, "forced_next_owner");
    applyStimulus(4'b0000);
    waitGrant(4'b0000, 5, "forced_release");
`endif

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
